// File: rtl/sha_bus_sequencer_if.sv
// rtl/sha_bus_sequencer_if.sv - processor bus and SHA-256 core handshake signals of the sequencer
interface sha_bus_sequencer_if;
  logic         cs;
  logic         rw;
  logic [15:0]  address;
  logic [15:0]  datain;
  logic [15:0]  dataout;
  logic [511:0] block;
  logic         core_start;
  logic         core_reset;
  logic         done;
  logic [255:0] hash;

  modport slave (
    input  cs, rw, address, datain, done, hash,
    output dataout, block, core_start, core_reset
  );

  modport master (
    output cs, rw, address, datain, done, hash,
    input  dataout, block, core_start, core_reset
  );
endinterface

// File: rtl/sha_bus_sequencer.sv
// rtl/sha_bus_sequencer.sv - SHA-256 block loader/padder and digest reader at 0x0300-0x0307
// Optional WAIT watchdog enabled by defining SHA_SEQ_TIMEOUT_EN.
module sha_bus_sequencer #(
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  sha_bus_sequencer_if.slave bus
);
  localparam logic [15:0] ADDR_CTRL   = 16'h0300;
  localparam logic [15:0] ADDR_DATA   = 16'h0302;
  localparam logic [15:0] ADDR_DIGEST = 16'h0304;
  localparam logic [15:0] ADDR_LEN    = 16'h0306;
  localparam logic [4:0]  MAX_WORDS   = 5'd27;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t       state;
  logic [511:0] block_q;
  logic [511:0] pad_block;
  logic [255:0] digest_q;
  logic [15:0]  dataout_q;
  logic         core_start_q;
  logic         core_reset_q;
  logic [4:0]   n;
  logic [3:0]   rd_ptr;
  logic         err;
  logic         done_flag;
  logic         busy;
  logic         wr;
  logic         rd;
  logic         soft_rst;
  logic         go;
  logic         data_wr;
  logic [8:0]   wr_base;
  logic [7:0]   rd_base;
  logic         unused_timeout;

`ifdef SHA_SEQ_TIMEOUT_EN
  logic [31:0]  wait_cnt;
`endif

  assign busy     = (state == START) || (state == WAIT);
  assign wr       = bus.cs && !bus.rw;
  assign rd       = bus.cs && bus.rw;
  assign soft_rst = wr && (bus.address == ADDR_CTRL) && (bus.datain == 16'd1);
  assign go       = wr && (bus.address == ADDR_CTRL) && (bus.datain == 16'd2);
  assign data_wr  = wr && (bus.address == ADDR_DATA);
  assign wr_base  = 9'd511 - {n, 4'd0};
  assign rd_base  = 8'd255 - {rd_ptr, 4'd0};
  assign unused_timeout = |TIMEOUT;

  assign bus.dataout    = dataout_q;
  assign bus.block      = block_q;
  assign bus.core_start = core_start_q;
  assign bus.core_reset = core_reset_q;

  // Loaded words are kept; the terminator, zero fill and bit length replace everything from word n on.
  always_comb begin
    pad_block = block_q;
    for (int i = 0; i < 28; i++) begin
      if (i == int'(n))
        pad_block[511 - 16*i -: 16] = 16'h8000;
      else if (i > int'(n))
        pad_block[511 - 16*i -: 16] = 16'h0000;
    end
    pad_block[63:0] = {55'd0, n, 4'd0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      block_q      <= '0;
      digest_q     <= '0;
      dataout_q    <= '0;
      core_start_q <= 1'b0;
      core_reset_q <= 1'b0;
      n            <= '0;
      rd_ptr       <= '0;
      err          <= 1'b0;
      done_flag    <= 1'b0;
`ifdef SHA_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      core_start_q <= 1'b0;
      core_reset_q <= 1'b0;

      case (state)
        START: begin
          state <= WAIT;
`ifdef SHA_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
`ifdef SHA_SEQ_TIMEOUT_EN
        WAIT: begin
          if (!bus.done) begin
            if (wait_cnt == 32'(TIMEOUT - 1)) begin
              err          <= 1'b1;
              core_reset_q <= 1'b1;
              state        <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
        end
`endif
        default: ;
      endcase

      // Bus accesses see the state as it was before any done-driven transition this cycle.
      if (rd) begin
        case (bus.address)
          ADDR_CTRL:   dataout_q <= {13'd0, err, busy, done_flag};
          ADDR_DIGEST: begin
            dataout_q <= digest_q[rd_base -: 16];
            rd_ptr    <= rd_ptr + 4'd1;
          end
          ADDR_LEN:    dataout_q <= {11'd0, n};
          default:     dataout_q <= 16'd0;
        endcase
      end

      if (data_wr) begin
        if (busy) begin
          err <= 1'b1;
        end else if (state == DONE) begin
          block_q[511 -: 16] <= bus.datain;
          n                  <= 5'd1;
          done_flag          <= 1'b0;
          state              <= IDLE;
        end else if (n == MAX_WORDS) begin
          err <= 1'b1;
        end else begin
          block_q[wr_base -: 16] <= bus.datain;
          n                      <= n + 5'd1;
        end
      end

      if (go) begin
        if (busy) begin
          err <= 1'b1;
        end else begin
          block_q      <= pad_block;
          core_start_q <= 1'b1;
          state        <= START;
        end
      end

      if ((state == WAIT) && bus.done) begin
        digest_q  <= bus.hash;
        done_flag <= 1'b1;
        rd_ptr    <= '0;
        state     <= DONE;
      end

      if (soft_rst) begin
        state        <= IDLE;
        block_q      <= '0;
        digest_q     <= '0;
        n            <= '0;
        rd_ptr       <= '0;
        err          <= 1'b0;
        done_flag    <= 1'b0;
        core_start_q <= 1'b0;
        core_reset_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sha_bus_sequencer.sv
// tb/tb_sha_bus_sequencer.sv - randomized self-checking bench for sha_bus_sequencer
`timescale 1ns/1ps
module tb_sha_bus_sequencer;
  localparam int TIMEOUT = 16;
  localparam logic [15:0] A_CTRL = 16'h0300;
  localparam logic [15:0] A_DATA = 16'h0302;
  localparam logic [15:0] A_DIG  = 16'h0304;
  localparam logic [15:0] A_LEN  = 16'h0306;

  logic clk = 1'b0;
  logic reset;

  sha_bus_sequencer_if bus ();

  sha_bus_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int start_pulses = 0;
  int reset_pulses = 0;

  always @(posedge clk) begin
    if (bus.core_start) start_pulses <= start_pulses + 1;
    if (bus.core_reset) reset_pulses <= reset_pulses + 1;
  end

  // Reference model: message as a word list, phase 0 = loading, 1 = hashing, 2 = digest ready.
  logic [15:0]  m_words [28];
  int           m_n;
  int           m_phase;
  bit           m_err;
  bit           m_flag;
  logic [255:0] m_hash;
  int           m_ptr;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] raw_block();
    logic [511:0] b = '0;
    for (int i = 0; i < m_n; i++) b[511 - 16*i -: 16] = m_words[i];
    return b;
  endfunction

  function automatic logic [511:0] padded_block();
    logic [511:0] b = raw_block();
    b[511 - 16*m_n -: 16] = 16'h8000;
    b[63:0] = 64'(m_n * 16);
    return b;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [15:0] m_status();
    return {13'd0, m_err, (m_phase == 1), m_flag};
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.address = a; bus.datain = d;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.address = a;
    @(negedge clk);
    bus.cs = 1'b0;
    d = bus.dataout;
  endtask

  task automatic m_soft_reset();
    bus_write(A_CTRL, 16'd1);
    check("core_reset_hi", bus.core_reset, 1'b1);
    m_n = 0; m_phase = 0; m_err = 0; m_flag = 0; m_hash = '0; m_ptr = 0;
    @(negedge clk);
    check("core_reset_lo", bus.core_reset, 1'b0);
  endtask

  task automatic m_data(input logic [15:0] w);
    bus_write(A_DATA, w);
    if (m_phase == 1) m_err = 1;
    else if (m_phase == 2) begin m_words[0] = w; m_n = 1; m_flag = 0; m_phase = 0; end
    else if (m_n == 27) m_err = 1;
    else begin m_words[m_n] = w; m_n++; end
  endtask

  task automatic m_go();
    bus_write(A_CTRL, 16'd2);
    if (m_phase == 1) begin
      m_err = 1;
    end else begin
      m_phase = 1;
      check("core_start_hi", bus.core_start, 1'b1);
      check("block_padded", bus.block, padded_block());
      @(negedge clk);
      check("core_start_lo", bus.core_start, 1'b0);
    end
  endtask

  task automatic m_done(input logic [255:0] h);
    @(negedge clk);
    bus.done = 1'b1; bus.hash = h;
    @(negedge clk);
    bus.done = 1'b0;
    if (m_phase == 1) begin m_hash = h; m_flag = 1; m_ptr = 0; m_phase = 2; end
  endtask

  task automatic chk_status(input string tag);
    logic [15:0] d;
    bus_read(A_CTRL, d);
    check(tag, d, m_status());
  endtask

  task automatic chk_len();
    logic [15:0] d;
    bus_read(A_LEN, d);
    check("len", d, 16'(m_n));
  endtask

  task automatic chk_digest(input int count);
    logic [15:0] d;
    for (int i = 0; i < count; i++) begin
      bus_read(A_DIG, d);
      check("digest", d, m_hash[255 - 16*m_ptr -: 16]);
      m_ptr = (m_ptr + 1) % 16;
    end
  endtask

  initial begin
    logic [15:0]  d;
    logic [255:0] h;
    int           cnt;
    int           sp;

    reset = 1'b1;
    bus.cs = 1'b0; bus.rw = 1'b0; bus.address = '0; bus.datain = '0;
    bus.done = 1'b0; bus.hash = '0;
    m_n = 0; m_phase = 0; m_err = 0; m_flag = 0; m_hash = '0; m_ptr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_dataout", bus.dataout, 16'd0);
    check("rst_block", bus.block, 512'd0);
    check("rst_core_start", bus.core_start, 1'b0);
    check("rst_core_reset", bus.core_reset, 1'b0);
    chk_status("rst_status");
    chk_len();

    // Single word 0x6162 with a known digest.
    m_data(16'h6162);
    m_go();
    check("block_6162", bus.block, {16'h6162, 16'h8000, 416'd0, 64'h10});
    chk_status("status_busy");
    check("status_busy_val", m_status(), 16'h0002);
    m_done({4{64'h0123_4567_89AB_CDEF}});
    chk_status("status_done");
    chk_digest(17);

    // DIGEST read in the same cycle that done rises: old word out, pointer cleared.
    m_go();
    h = rand256();
    @(negedge clk);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.address = A_DIG;
    bus.done = 1'b1; bus.hash = h;
    @(negedge clk);
    bus.cs = 1'b0; bus.done = 1'b0;
    check("digest_race", bus.dataout, m_hash[255 - 16*m_ptr -: 16]);
    m_hash = h; m_flag = 1; m_ptr = 0; m_phase = 2;
    chk_digest(2);

    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) begin
        m_soft_reset();
        cnt = $urandom_range(0, 27);
      end else begin
        cnt = $urandom_range(1, 27);
      end
      for (int w = 0; w < cnt; w++) m_data(16'($urandom));
      chk_len();
      chk_status("status_loaded");
      m_go();
      chk_status("status_hashing");
      m_done(rand256());
      chk_status("status_ready");
      chk_digest($urandom_range(1, 20));
    end

    // Overflow: the 28th word is dropped and flagged.
    m_soft_reset();
    for (int w = 0; w < 28; w++) m_data(16'(w));
    chk_len();
    chk_status("status_overflow");
    check("block_overflow", bus.block, raw_block());
    check("word26", bus.block[95:80], 16'h001A);
    check("word27_absent", bus.block[79:64], 16'h0000);

    // Empty message, then a GO while hashing.
    m_soft_reset();
    sp = start_pulses;
    m_go();
    check("empty_first", bus.block[511:496], 16'h8000);
    check("empty_len", bus.block[63:0], 64'd0);
    m_go();
    chk_status("status_go_busy");
    check("start_pulses", start_pulses - sp, 1);

    // Soft reset mid-WAIT, then a late done.
    m_soft_reset();
    chk_status("status_softrst");
    chk_len();
    m_done(rand256());
    chk_status("status_late_done");
    chk_digest(1);

`ifdef SHA_SEQ_TIMEOUT_EN
    m_soft_reset();
    for (int w = 0; w < 3; w++) m_data(16'($urandom));
    sp = reset_pulses;
    m_go();
    repeat (TIMEOUT + 4) @(negedge clk);
    m_err = 1; m_phase = 0;
    check("timeout_reset_pulse", reset_pulses - sp, 1);
    chk_status("status_timeout");
    chk_len();
`endif

    // Hardware reset while hashing.
    m_data(16'($urandom));
    m_go();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("hw_dataout", bus.dataout, 16'd0);
    check("hw_block", bus.block, 512'd0);
    check("hw_core_start", bus.core_start, 1'b0);
    check("hw_core_reset", bus.core_reset, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_n = 0; m_phase = 0; m_err = 0; m_flag = 0; m_hash = '0; m_ptr = 0;
    chk_status("hw_status");
    chk_len();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
